// File: rtl/mult_button_sequencer_pkg.sv
// Shared state encoding for the multiplier front panel (also used by the LED display driver).
package mult_button_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT_A = 3'd0,
    S_WAIT_B = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_SHOW   = 3'd4
  } state_e;

endpackage

// File: rtl/mult_button_sequencer_button.sv
// button_debounce: 2-FF sync, optional debounce (MULT_BUTTON_DEBOUNCE_EN), rising-edge press pulse.
// Latency: 2 + DEBOUNCE_CYCLES + 1 cycles (3 without debounce); no backpressure, press is a one-cycle pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clk_in,
  input  logic Reset_in,
  input  logic Button_in,
  output logic Press_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic press_q, press_d;
  logic stable;

`ifdef MULT_BUTTON_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Any sample that agrees with the stable level restarts the stability window.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign stable = sync2_q;
`endif

  always_comb begin
    sync1_d = Button_in;
    sync2_d = sync1_q;
    prev_d  = stable;
    press_d = stable & ~prev_q;
  end

  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign Press_out = press_q;

endmodule

// File: rtl/mult_button_sequencer.sv
// Front-panel sequencer: press latches A then B, pulses start, captures product and shows it (MULT_BUTTON_DEBOUNCE_EN selects debounce).
// Latency: B latch to start 1 cycle, done to Valid_out 1 cycle; no backpressure, presses outside WAIT/SHOW states are dropped.
module mult_button_sequencer
  import mult_button_sequencer_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 Clk_in,
  input  logic                 Reset_in,
  input  logic                 Button_in,
  input  logic [WIDTH-1:0]     Data_in,
  output logic [WIDTH-1:0]     Mul_a_out,
  output logic [WIDTH-1:0]     Mul_b_out,
  output logic                 Mul_start_out,
  input  logic                 Mul_done_in,
  input  logic [2*WIDTH-1:0]   Product_in,
  output logic [2*WIDTH-1:0]   Product_out,
  output logic                 Valid_out,
  output logic [STATE_W-1:0]   State_out
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .Clk_in   (Clk_in),
    .Reset_in (Reset_in),
    .Button_in(Button_in),
    .Press_out(press)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    case (state_q)
      S_WAIT_A: if (press) begin
        a_d     = Data_in;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: if (press) begin
        b_d     = Data_in;
        state_d = S_START;
      end
      S_START:  state_d = S_RUN;
      S_RUN:    if (Mul_done_in) begin
        prod_d  = Product_in;
        state_d = S_SHOW;
      end
      S_SHOW:   if (press) state_d = S_WAIT_A;
      default:  state_d = S_WAIT_A;
    endcase
  end

  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      state_q <= S_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  // Start and valid are pure state decodes so they can never outlive their state.
  assign Mul_start_out = (state_q == S_START);
  assign Valid_out     = (state_q == S_SHOW);
  assign Mul_a_out     = a_q;
  assign Mul_b_out     = b_q;
  assign Product_out   = prod_q;
  assign State_out     = state_q;

endmodule

// File: tb/tb_mult_button_sequencer.sv
// Scoreboard bench for mult_button_sequencer: directed presses, model done pulses, debounce timing.
module tb_mult_button_sequencer;

  localparam int W    = 8;
  localparam int DC   = 4;
  localparam int HOLD = 12;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } ops_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           button;
  logic [W-1:0]   data;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] prod_in, prod_out;
  logic           valid;
  logic [2:0]     state;

  int checks   = 0;
  int failures = 0;

  ops_t           start_q[$];
  logic [2*W-1:0] prod_q[$];
  ops_t           mon_ops;
  logic [2*W-1:0] mon_prod;
  logic           valid_prev = 1'b0;

  mult_button_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .Clk_in       (clk),
    .Reset_in     (rst),
    .Button_in    (button),
    .Data_in      (data),
    .Mul_a_out    (mul_a),
    .Mul_b_out    (mul_b),
    .Mul_start_out(mul_start),
    .Mul_done_in  (mul_done),
    .Product_in   (prod_in),
    .Product_out  (prod_out),
    .Valid_out    (valid),
    .State_out    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [W-1:0] d);
    data   = d;
    button = 1'b1;
    tick(HOLD);
    button = 1'b0;
    tick(HOLD);
  endtask

  task automatic done_pulse(input logic [2*W-1:0] p);
    prod_in  = p;
    mul_done = 1'b1;
    tick(1);
    mul_done = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_state_reached", 32'(state), 32'(s));
  endtask

  // Monitor: every start pulse and every rising Valid_out consumes one expectation.
  always @(negedge clk) begin
    if (mul_start) begin
      if (start_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL start_unexpected: start pulse with a=0x%0h b=0x%0h, none expected", mul_a, mul_b);
      end else begin
        mon_ops = start_q.pop_front();
        check("start_a", 32'(mul_a), 32'(mon_ops.a));
        check("start_b", 32'(mul_b), 32'(mon_ops.b));
      end
    end
    if (valid && !valid_prev) begin
      if (prod_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL valid_unexpected: product 0x%0h shown, none expected", prod_out);
      end else begin
        mon_prod = prod_q.pop_front();
        check("show_product", 32'(prod_out), 32'(mon_prod));
        check("show_state", 32'(state), 32'd4);
      end
    end
    valid_prev = valid;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; button = 1'b0; data = '0; mul_done = 1'b0; prod_in = '0;
    tick(3);
    rst = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_a", 32'(mul_a), 32'd0);
    check("rst_b", 32'(mul_b), 32'd0);
    check("rst_start", 32'(mul_start), 32'd0);
    check("rst_product", 32'(prod_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);

    // 0x0C x 0x0D
    start_q.push_back('{a: 8'h0C, b: 8'h0D});
    press(8'h0C);
    check("t1_state_b", 32'(state), 32'd1);
    check("t1_a", 32'(mul_a), 32'h0C);
    check("t1_b_untouched", 32'(mul_b), 32'd0);
    press(8'h0D);
    check("t1_state_run", 32'(state), 32'd3);
    check("t1_b", 32'(mul_b), 32'h0D);
    tick(8);
    prod_q.push_back(16'h009C);
    done_pulse(16'h009C);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_state_show", 32'(state), 32'd4);
    check("t1_product", 32'(prod_out), 32'h009C);

    // Press in SHOW, then a press dropped during RUN
    press(8'h01);
    check("t3_state_a", 32'(state), 32'd0);
    check("t3_valid_low", 32'(valid), 32'd0);
    check("t3_product_held", 32'(prod_out), 32'h009C);
    start_q.push_back('{a: 8'h03, b: 8'h05});
    press(8'h03);
    press(8'h05);
    press(8'h77);
    check("t3_run_press_dropped", 32'(state), 32'd3);
    check("t3_a_stable", 32'(mul_a), 32'h03);
    check("t3_b_stable", 32'(mul_b), 32'h05);
    prod_q.push_back(16'h000F);
    done_pulse(16'h000F);
    check("t3_state_show", 32'(state), 32'd4);
    tick(10);
    check("t3_no_replay", 32'(state), 32'd4);
    check("t3_a_kept", 32'(mul_a), 32'h03);

    // Done outside RUN: in WAIT_B and in the START cycle
    rst = 1'b1; tick(1); rst = 1'b0;
    check("t4_rst_product", 32'(prod_out), 32'd0);
    press(8'h02);
    check("t4_state_b", 32'(state), 32'd1);
    prod_in  = 16'hABCD;
    mul_done = 1'b1;
    tick(3);
    mul_done = 1'b0;
    check("t4_waitb_state", 32'(state), 32'd1);
    check("t4_waitb_no_capture", 32'(prod_out), 32'd0);
    start_q.push_back('{a: 8'h02, b: 8'h04});
    data   = 8'h04;
    button = 1'b1;
    wait_state(3'd2, 20);
    mul_done = 1'b1;
    tick(1);
    mul_done = 1'b0;
    check("t4_start_to_run", 32'(state), 32'd3);
    check("t4_start_no_capture", 32'(prod_out), 32'd0);
    button = 1'b0;
    tick(HOLD);
    check("t4_still_run", 32'(state), 32'd3);

    // One-cycle reset in RUN, then a stale done
    rst = 1'b1; tick(1); rst = 1'b0;
    check("t5_state", 32'(state), 32'd0);
    check("t5_a", 32'(mul_a), 32'd0);
    check("t5_b", 32'(mul_b), 32'd0);
    check("t5_product", 32'(prod_out), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_start", 32'(mul_start), 32'd0);
    done_pulse(16'h1234);
    tick(2);
    check("t5_stale_done_state", 32'(state), 32'd0);
    check("t5_stale_done_product", 32'(prod_out), 32'd0);

    // 0xFF x 0xFF
    start_q.push_back('{a: 8'hFF, b: 8'hFF});
    press(8'hFF);
    press(8'hFF);
    prod_q.push_back(16'hFE01);
    done_pulse(16'hFE01);
    check("t6_product", 32'(prod_out), 32'hFE01);
    press(8'h00);
    check("t6_state_a", 32'(state), 32'd0);
    check("t6_product_held", 32'(prod_out), 32'hFE01);
    check("t6_valid_low", 32'(valid), 32'd0);

    // Button filtering and press latency
    rst = 1'b1; tick(1); rst = 1'b0;
    data = 8'h5A;
`ifdef MULT_BUTTON_DEBOUNCE_EN
    button = 1'b1; tick(3); button = 1'b0; tick(10);
    check("t2_glitch_ignored", 32'(state), 32'd0);
    repeat (3) begin
      button = 1'b1; tick(2);
      button = 1'b0; tick(1);
    end
    button = 1'b1;
    tick(7);
    check("t2_press_not_early", 32'(state), 32'd0);
    tick(1);
    check("t2_press_on_time", 32'(state), 32'd1);
    tick(20);
    check("t2_single_press", 32'(state), 32'd1);
    repeat (3) begin
      button = 1'b0; tick(2);
      button = 1'b1; tick(1);
    end
    button = 1'b0;
    tick(20);
    check("t2_release_no_press", 32'(state), 32'd1);
`else
    button = 1'b1;
    tick(3);
    check("t2_press_not_early", 32'(state), 32'd0);
    tick(1);
    check("t2_press_on_time", 32'(state), 32'd1);
    button = 1'b0;
    tick(10);
    check("t2_single_press", 32'(state), 32'd1);
`endif
    check("t2_a_latched", 32'(mul_a), 32'h5A);

    tick(2);
    check("start_queue_drained", 32'(start_q.size()), 32'd0);
    check("product_queue_drained", 32'(prod_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
